// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep extractor.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned N_INPUTS_DEF = 4;
  localparam int unsigned SETTLE_DEF   = 1;
  localparam int unsigned SETTLE_W     = 8;

  // Truth-table width for an n-input gate.
  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_extractor_if.sv
// Harness-side bundle of the sweep extractor: control, gate drive/sense, result.
// Optional compare ports exist only when TT_SWEEP_COMPARE_EN is defined.
interface tt_sweep_extractor_if
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_INPUTS = N_INPUTS_DEF
) ();

  localparam int unsigned TT_WIDTH = tt_width(N_INPUTS);

  logic                start;
  logic                busy;
  logic                done;
  logic [N_INPUTS-1:0] dut_in;
  logic                dut_out;
  logic [TT_WIDTH-1:0] truth_table;

`ifdef TT_SWEEP_COMPARE_EN
  logic [TT_WIDTH-1:0] expected;
  logic                match;
  logic [TT_WIDTH-1:0] mismatch_mask;

  modport master (output start, dut_out, expected,
                  input  busy, done, dut_in, truth_table, match, mismatch_mask);
  modport slave  (input  start, dut_out, expected,
                  output busy, done, dut_in, truth_table, match, mismatch_mask);
`else
  modport master (output start, dut_out,
                  input  busy, done, dut_in, truth_table);
  modport slave  (input  start, dut_out,
                  output busy, done, dut_in, truth_table);
`endif

endinterface

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that flags when the settle interval has elapsed.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int unsigned W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_q;

  // Load has priority; otherwise count down once per cycle until zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      expired <= 1'b1;
    end else if (load) begin
      count_q <= value;
      expired <= (value == '0);
    end else if (!expired) begin
      count_q <= count_q - W'(1);
      expired <= (count_q == W'(1));
    end
  end

endmodule

// File: rtl/tt_sweep_extractor.sv
// Sweeps every input vector through an external gate and assembles its truth table.
// Optional result comparison against an expected word: define TT_SWEEP_COMPARE_EN.
module tt_sweep_extractor
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_INPUTS      = N_INPUTS_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  tt_sweep_extractor_if.slave bus
);

  localparam int unsigned    TT_WIDTH   = tt_width(N_INPUTS);
  localparam int unsigned    IDX_W      = N_INPUTS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TT_WIDTH - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_CYCLES);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TT_WIDTH-1:0] shadow_q, shadow_d;
  logic [TT_WIDTH-1:0] tt_q, tt_d;
  logic [N_INPUTS-1:0] dut_in_q, dut_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timer_load;
  logic                timer_expired;
`ifdef TT_SWEEP_COMPARE_EN
  logic                match_q, match_d;
  logic [TT_WIDTH-1:0] mask_q, mask_d;
`endif

  tt_settle_timer #(.W(SETTLE_W)) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .value   (SETTLE_VAL),
    .expired (timer_expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      tt_q     <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
      match_q  <= 1'b0;
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tt_q     <= tt_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TT_SWEEP_COMPARE_EN
      match_q  <= match_d;
      mask_q   <= mask_d;
`endif
    end
  end

  // Next-state and next-output logic; the final sample is folded straight into
  // the result so truth_table is valid in the same cycle as the done pulse.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    tt_d       = tt_q;
    dut_in_d   = dut_in_q;
    timer_load = 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
    match_d    = match_q;
    mask_d     = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = DRIVE;
          idx_d      = '0;
          shadow_d   = '0;
          dut_in_d   = '0;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        if (timer_expired) state_d = SAMPLE;
      end
      SAMPLE: begin
        shadow_d[idx_q[N_INPUTS-1:0]] = bus.dut_out;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          tt_d    = shadow_d;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          dut_in_d   = idx_d[N_INPUTS-1:0];
          timer_load = 1'b1;
          state_d    = DRIVE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        dut_in_d = '0;
`ifdef TT_SWEEP_COMPARE_EN
        mask_d   = tt_q ^ bus.expected;
        match_d  = (tt_q == bus.expected);
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.dut_in      = dut_in_q;
  assign bus.truth_table = tt_q;
`ifdef TT_SWEEP_COMPARE_EN
  assign bus.match         = match_q;
  assign bus.mismatch_mask = mask_q;
`endif

endmodule

// File: tb/tb_tt_sweep_extractor.sv
// Self-checking bench: three extractor configurations driven by behavioural gate
// models, checked against a timeline-based reference of what each sample sees.
module tb_tt_sweep_extractor;
  import tt_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] prev_tt [3];

  always #5 clk = ~clk;

  // sel 0: N=4 SETTLE=1, sel 1: N=4 SETTLE=0, sel 2: N=2 SETTLE=1
  tt_sweep_extractor_if #(.N_INPUTS(4)) if4 ();
  tt_sweep_extractor_if #(.N_INPUTS(4)) if0 ();
  tt_sweep_extractor_if #(.N_INPUTS(2)) if2 ();

  tt_sweep_extractor #(.N_INPUTS(4), .SETTLE_CYCLES(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave));
  tt_sweep_extractor #(.N_INPUTS(4), .SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  tt_sweep_extractor #(.N_INPUTS(2), .SETTLE_CYCLES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Gate models: function word indexed by the input vector, with 0/1/2 cycles of latency.
  logic [15:0] w4, w0;
  logic [3:0]  w2;
  int          lat4, lat0, lat2;
  logic        p4a, p4b, p0a, p0b, p2a, p2b;

  always @(posedge clk) begin
    p4a <= w4[if4.dut_in]; p4b <= p4a;
    p0a <= w0[if0.dut_in]; p0b <= p0a;
    p2a <= w2[if2.dut_in]; p2b <= p2a;
  end

  assign if4.dut_out = (lat4 == 0) ? w4[if4.dut_in] : (lat4 == 1) ? p4a : p4b;
  assign if0.dut_out = (lat0 == 0) ? w0[if0.dut_in] : (lat0 == 1) ? p0a : p0b;
  assign if2.dut_out = (lat2 == 0) ? w2[if2.dut_in] : (lat2 == 1) ? p2a : p2b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit i = gate output seen at the last cycle of vector i. Vector i occupies
  // cycles i*(s+2) .. i*(s+2)+s+1 after acceptance; before that the input is 0.
  function automatic logic [15:0] ref_word(input logic [15:0] f, input int n,
                                           input int s, input int lat);
    logic [15:0] r;
    int t, v;
    r = '0;
    for (int i = 0; i < (1 << n); i++) begin
      t = i * (s + 2) + s + 1 - lat;
      v = (t < 0) ? 0 : t / (s + 2);
      r[i] = f[v];
    end
    return r;
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       if4.start = v;
      1:       if0.start = v;
      default: if2.start = v;
    endcase
  endtask

  task automatic peek(input int sel, output logic b, output logic d,
                      output logic [3:0] di, output logic [15:0] tt);
    case (sel)
      0: begin b = if4.busy; d = if4.done; di = if4.dut_in; tt = if4.truth_table; end
      1: begin b = if0.busy; d = if0.done; di = if0.dut_in; tt = if0.truth_table; end
      default: begin
        b = if2.busy; d = if2.done; di = 4'(if2.dut_in); tt = 16'(if2.truth_table);
      end
    endcase
  endtask

  // One complete sweep on the selected extractor with full result/timing checks.
  task automatic run_sweep(input int sel, input logic [15:0] word, input int lat,
                           input string tag);
    int n, s, lat_got, seq_err;
    logic b, d;
    logic [3:0] di;
    logic [15:0] tt, exp;
    n = (sel == 2) ? 2 : 4;
    s = (sel == 1) ? 0 : 1;
    case (sel)
      0:       begin w4 = word;      lat4 = lat; end
      1:       begin w0 = word;      lat0 = lat; end
      default: begin w2 = word[3:0]; lat2 = lat; end
    endcase
    exp = ref_word(word, n, s, lat);
    repeat (3) @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    lat_got = -1;
    seq_err = 0;
    tt = '0;
    for (int c = 1; c <= 200 && lat_got < 0; c++) begin
      @(negedge clk);
      if (c == 1) set_start(sel, 1'b0);
      peek(sel, b, d, di, tt);
      if (c == 1) check({tag, "_busy_rise"}, 32'(b), 32'd1);
      if (c == 5) check({tag, "_tt_held"}, 32'(tt), 32'(prev_tt[sel]));
      if (d) lat_got = c;
      else if (di !== 4'((c - 1) / (s + 2))) seq_err++;
    end
    if (lat_got < 0) begin
      check({tag, "_timeout"}, 32'(lat_got), 32'((1 << n) * (s + 2) + 1));
      return;
    end
    check({tag, "_latency"}, 32'(lat_got), 32'((1 << n) * (s + 2) + 1));
    check({tag, "_dut_in_seq_errs"}, 32'(seq_err), 32'd0);
    check({tag, "_truth_table"}, 32'(tt), 32'(exp));
    check({tag, "_busy_at_done"}, 32'(b), 32'd1);
    prev_tt[sel] = tt;
    @(negedge clk);
    peek(sel, b, d, di, tt);
    check({tag, "_idle_after"}, 32'({b, d}), 32'd0);
  endtask

  initial begin
    int pulses, dc[2], found;
    logic [15:0] tt_seen[2];
    logic b, d;
    logic [3:0] di;
    logic [15:0] tt;

    rst_n = 1'b0;
    if4.start = 1'b0; if0.start = 1'b0; if2.start = 1'b0;
    w4 = '0; w0 = '0; w2 = '0;
    lat4 = 0; lat0 = 0; lat2 = 0;
    prev_tt[0] = '0; prev_tt[1] = '0; prev_tt[2] = '0;
`ifdef TT_SWEEP_COMPARE_EN
    if4.expected = 16'hFC79; if0.expected = '0; if2.expected = '0;
`endif
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      peek(k, b, d, di, tt);
      check("reset_state", 32'({b, d, di, tt}), 32'd0);
    end
`ifdef TT_SWEEP_COMPARE_EN
    check("reset_cmp", 32'({if4.match, if4.mismatch_mask}), 32'd0);
`endif
    rst_n = 1'b1;

    // Reference gate and random functions, combinational output.
    run_sweep(0, 16'hFC79, 0, "fc79");
    for (int k = 0; k < 3; k++) run_sweep(0, 16'($urandom), 0, "rand4");

    // Back-to-back with start held: constant 0 then constant 1.
    w4 = 16'h0000; lat4 = 0;
    pulses = 0; dc[0] = 0; dc[1] = 0;
    tt_seen[0] = 16'h5A5A; tt_seen[1] = 16'h5A5A;
    repeat (3) @(negedge clk);
    if4.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      if (if4.done) begin
        if (pulses < 2) begin tt_seen[pulses] = if4.truth_table; dc[pulses] = c; end
        pulses++;
        if (pulses == 1) w4 = 16'hFFFF;
      end
      if (pulses == 1 && c == dc[0] + 2) if4.start = 1'b0;
    end
    if4.start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_first_lat", 32'(dc[0]), 32'd49);
    check("b2b_gap", 32'(dc[1] - dc[0]), 32'd50);
    check("b2b_tt0", 32'(tt_seen[0]), 32'h0000);
    check("b2b_tt1", 32'(tt_seen[1]), 32'hFFFF);
    prev_tt[0] = tt_seen[1];

    // Reset at vector 7 of a sweep.
    w4 = 16'($urandom);
    repeat (3) @(negedge clk);
    if4.start = 1'b1;
    @(posedge clk);
    found = 0;
    for (int c = 1; c <= 100 && found == 0; c++) begin
      @(negedge clk);
      if4.start = 1'b0;
      if (if4.dut_in == 4'd7) found = 1;
    end
    check("rst_reached_vec7", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          32'({if4.busy, if4.done, if4.dut_in, if4.truth_table}), 32'd0);
    pulses = 0;
    repeat (3) begin @(negedge clk); if (if4.done) pulses++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (if4.done) pulses++; end
    check("rst_no_done", 32'(pulses), 32'd0);
    prev_tt[0] = '0; prev_tt[1] = '0; prev_tt[2] = '0;
    run_sweep(0, 16'($urandom), 0, "post_rst");

    // Registered gate models.
    run_sweep(1, 16'hFC79, 1, "s0_lat1");
    run_sweep(1, 16'hFC79, 2, "s0_lat2");
    run_sweep(1, 16'($urandom), 2, "s0_lat2_rand");
    run_sweep(0, 16'hFC79, 2, "s1_lat2");

    // Two-input extractor.
    run_sweep(2, 16'h0006, 0, "n2_xor");
    run_sweep(2, 16'($urandom_range(0, 15)), 0, "n2_rand");

`ifdef TT_SWEEP_COMPARE_EN
    if4.expected = 16'hFC79;
    run_sweep(0, 16'hFC79 ^ 16'h0020, 0, "cmp_bad");
    check("cmp_bad_match", 32'(if4.match), 32'd0);
    check("cmp_bad_mask", 32'(if4.mismatch_mask), 32'h0020);
    run_sweep(0, 16'hFC79, 0, "cmp_good");
    check("cmp_good_match", 32'(if4.match), 32'd1);
    check("cmp_good_mask", 32'(if4.mismatch_mask), 32'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
